// File: rtl/sbox_share_sched.sv
// sbox_share_sched: time-multiplexes one 32-bit substitution unit between
// key expansion (single-word SubWord, always forward) and the round datapath
// (128-bit SubBytes / InvSubBytes, issued as four words MSW first).
// Round-robin arbitration per transaction, one transaction in flight.
// Optional build macro SBOX_SCHED_PERF_EN adds saturating handshake counters.
//
// state  | meaning
// IDLE   | arbitrate and accept one request
// KY_RUN | issue the latched key word
// ST_RUN | issue state words 0..3, MSW first
// DRAIN  | SUB_LAT=1 only: capture the final word
// KY_RSP | key result valid, wait for ky_rsp_ready
// ST_RSP | state result valid, wait for st_rsp_ready
module sbox_share_sched #(
  parameter int SUB_LAT = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ky_req_valid,
  output logic         ky_req_ready,
  input  logic [31:0]  ky_req_word,
  output logic         ky_rsp_valid,
  input  logic         ky_rsp_ready,
  output logic [31:0]  ky_rsp_word,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic         st_req_dir,
  input  logic [127:0] st_req_data,
  output logic         st_rsp_valid,
  input  logic         st_rsp_ready,
  output logic [127:0] st_rsp_data,
  output logic         sub_valid,
  output logic         sub_dir,
  output logic [31:0]  sub_word,
  input  logic [31:0]  sub_result
`ifdef SBOX_SCHED_PERF_EN
  ,
  input  logic         perf_clr,
  output logic [15:0]  perf_ky_cnt,
  output logic [15:0]  perf_st_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KY_RUN = 3'd1,
    ST_RUN = 3'd2,
    DRAIN  = 3'd3,
    KY_RSP = 3'd4,
    ST_RSP = 3'd5
  } state_t;

  state_t       state;
  logic [1:0]   cnt;         // index of the word currently on sub_word
  logic         last_st;     // 1 = last grant went to the state requester
  logic         cur_st;      // 1 = transaction in flight is a state request
  logic [127:0] data_q;
  logic         cap_d;       // an issue happened last cycle (SUB_LAT=1 capture)
  logic [1:0]   cap_slot_d;
  logic         cap_en;
  logic [1:0]   cap_slot;
  logic         ky_grant;
  logic         st_grant;

  function automatic logic [31:0] word_sel(input logic [127:0] d, input logic [1:0] k);
    logic [31:0] w;
    case (k)
      2'd0:    w = d[127:96];
      2'd1:    w = d[95:64];
      2'd2:    w = d[63:32];
      default: w = d[31:0];
    endcase
    return w;
  endfunction

  // Grant decode: ties go to the requester that was not served last.
  // Gated by reset_n so nothing can be accepted while reset is held.
  always_comb begin
    ky_grant = 1'b0;
    st_grant = 1'b0;
    if (reset_n && state == IDLE) begin
      ky_grant = ky_req_valid && (!st_req_valid || last_st);
      st_grant = st_req_valid && (!ky_req_valid || !last_st);
    end
  end

  assign ky_req_ready = ky_grant;
  assign st_req_ready = st_grant;

  // Capture point: issue cycle for a combinational unit, one cycle later otherwise.
  always_comb begin
    cap_en   = sub_valid;
    cap_slot = cnt;
    if (SUB_LAT != 0) begin
      cap_en   = cap_d;
      cap_slot = cap_slot_d;
    end
  end

  // Scheduler FSM with registered issue and response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      last_st      <= 1'b1;
      cur_st       <= 1'b0;
      data_q       <= '0;
      cap_d        <= 1'b0;
      cap_slot_d   <= 2'd0;
      sub_valid    <= 1'b0;
      sub_dir      <= 1'b0;
      sub_word     <= '0;
      ky_rsp_valid <= 1'b0;
      ky_rsp_word  <= '0;
      st_rsp_valid <= 1'b0;
      st_rsp_data  <= '0;
    end else begin
      cap_d      <= (SUB_LAT != 0) && sub_valid;
      cap_slot_d <= cnt;

      if (cap_en) begin
        if (!cur_st) begin
          ky_rsp_word <= sub_result;
        end else begin
          case (cap_slot)
            2'd0:    st_rsp_data[127:96] <= sub_result;
            2'd1:    st_rsp_data[95:64]  <= sub_result;
            2'd2:    st_rsp_data[63:32]  <= sub_result;
            default: st_rsp_data[31:0]   <= sub_result;
          endcase
        end
      end

      case (state)
        IDLE: begin
          if (ky_grant) begin
            sub_valid <= 1'b1;
            sub_word  <= ky_req_word;
            sub_dir   <= 1'b0;
            cur_st    <= 1'b0;
            last_st   <= 1'b0;
            cnt       <= 2'd0;
            state     <= KY_RUN;
          end else if (st_grant) begin
            data_q    <= st_req_data;
            sub_valid <= 1'b1;
            sub_word  <= st_req_data[127:96];
            sub_dir   <= st_req_dir;
            cur_st    <= 1'b1;
            last_st   <= 1'b1;
            cnt       <= 2'd0;
            state     <= ST_RUN;
          end
        end
        KY_RUN: begin
          sub_valid <= 1'b0;
          if (SUB_LAT == 0) begin
            ky_rsp_valid <= 1'b1;
            state        <= KY_RSP;
          end else begin
            state <= DRAIN;
          end
        end
        ST_RUN: begin
          if (cnt == 2'd3) begin
            sub_valid <= 1'b0;
            if (SUB_LAT == 0) begin
              st_rsp_valid <= 1'b1;
              state        <= ST_RSP;
            end else begin
              state <= DRAIN;
            end
          end else begin
            cnt      <= cnt + 2'd1;
            sub_word <= word_sel(data_q, cnt + 2'd1);
          end
        end
        DRAIN: begin
          if (cur_st) begin
            st_rsp_valid <= 1'b1;
            state        <= ST_RSP;
          end else begin
            ky_rsp_valid <= 1'b1;
            state        <= KY_RSP;
          end
        end
        KY_RSP: begin
          if (ky_rsp_ready) begin
            ky_rsp_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        ST_RSP: begin
          if (st_rsp_ready) begin
            st_rsp_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SBOX_SCHED_PERF_EN
  // Saturating counts of completed response handshakes; clear wins over count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_ky_cnt <= '0;
      perf_st_cnt <= '0;
    end else if (perf_clr) begin
      perf_ky_cnt <= '0;
      perf_st_cnt <= '0;
    end else begin
      if (ky_rsp_valid && ky_rsp_ready && perf_ky_cnt != 16'hffff)
        perf_ky_cnt <= perf_ky_cnt + 16'd1;
      if (st_rsp_valid && st_rsp_ready && perf_st_cnt != 16'hffff)
        perf_st_cnt <= perf_st_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sbox_share_sched.sv
// Self-checking bench for sbox_share_sched: a SUB_LAT=0 instance driven by a
// vector table, a round-robin run and stall/reset sequences, plus a SUB_LAT=1
// instance for the registered-unit timing.
module tb_sbox_share_sched;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // SUB_LAT=0 instance
  logic         ky_req_valid = 0, ky_req_ready, ky_rsp_valid, ky_rsp_ready = 0;
  logic [31:0]  ky_req_word = 0, ky_rsp_word;
  logic         st_req_valid = 0, st_req_ready, st_req_dir = 0, st_rsp_valid, st_rsp_ready = 0;
  logic [127:0] st_req_data = 0, st_rsp_data;
  logic         sub_valid, sub_dir;
  logic [31:0]  sub_word, sub_result;

  // SUB_LAT=1 instance
  logic         ky_req_valid1 = 0, ky_req_ready1, ky_rsp_valid1, ky_rsp_ready1 = 1;
  logic [31:0]  ky_req_word1 = 0, ky_rsp_word1;
  logic         st_req_valid1 = 0, st_req_ready1, st_req_dir1 = 0, st_rsp_valid1, st_rsp_ready1 = 1;
  logic [127:0] st_req_data1 = 0, st_rsp_data1;
  logic         sub_valid1, sub_dir1;
  logic [31:0]  sub_word1;
  logic [31:0]  sub_result1 = 0;

`ifdef SBOX_SCHED_PERF_EN
  logic [15:0] pk0, ps0, pk1, ps1;
`endif

  sbox_share_sched #(.SUB_LAT(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .ky_req_valid(ky_req_valid), .ky_req_ready(ky_req_ready), .ky_req_word(ky_req_word),
    .ky_rsp_valid(ky_rsp_valid), .ky_rsp_ready(ky_rsp_ready), .ky_rsp_word(ky_rsp_word),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_req_dir(st_req_dir),
    .st_req_data(st_req_data), .st_rsp_valid(st_rsp_valid), .st_rsp_ready(st_rsp_ready),
    .st_rsp_data(st_rsp_data), .sub_valid(sub_valid), .sub_dir(sub_dir),
    .sub_word(sub_word), .sub_result(sub_result)
`ifdef SBOX_SCHED_PERF_EN
    , .perf_clr(1'b0), .perf_ky_cnt(pk0), .perf_st_cnt(ps0)
`endif
  );

  sbox_share_sched #(.SUB_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .ky_req_valid(ky_req_valid1), .ky_req_ready(ky_req_ready1), .ky_req_word(ky_req_word1),
    .ky_rsp_valid(ky_rsp_valid1), .ky_rsp_ready(ky_rsp_ready1), .ky_rsp_word(ky_rsp_word1),
    .st_req_valid(st_req_valid1), .st_req_ready(st_req_ready1), .st_req_dir(st_req_dir1),
    .st_req_data(st_req_data1), .st_rsp_valid(st_rsp_valid1), .st_rsp_ready(st_rsp_ready1),
    .st_rsp_data(st_rsp_data1), .sub_valid(sub_valid1), .sub_dir(sub_dir1),
    .sub_word(sub_word1), .sub_result(sub_result1)
`ifdef SBOX_SCHED_PERF_EN
    , .perf_clr(1'b0), .perf_ky_cnt(pk1), .perf_st_cnt(ps1)
`endif
  );

  // Reference AES S-box tables, built from GF(2^8) inverse plus affine map.
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w, input logic inv);
    logic [31:0] r;
    logic [7:0]  b;
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      r[8*i +: 8] = inv ? isb[b] : sb[b];
    end
    return r;
  endfunction

  function automatic logic [127:0] substate(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = subword(d[32*i +: 32], inv);
    return r;
  endfunction

  // Substitution unit models: combinational for dut0, one-cycle registered for dut1.
  always_comb sub_result = subword(sub_word, sub_dir);
  always @(posedge clk) if (sub_valid1) sub_result1 <= subword(sub_word1, sub_dir1);

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0]  ky_q[$];
  logic [127:0] st_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         is_st;
    logic         dir;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[7];

  // One request on dut0 with rsp_ready high; checks issue words, latency, result.
  task automatic run_vec(input vec_t v);
    int n, lat, nis;
    logic got;
    logic [127:0] sh;
    @(negedge clk);
    if (v.is_st) begin
      st_req_valid = 1; st_req_dir = v.dir; st_req_data = v.data;
    end else begin
      ky_req_valid = 1; ky_req_word = v.data[31:0];
    end
    n = 0;
    #1;
    while (!(v.is_st ? st_req_ready : ky_req_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("accept", n < 20, 1);
    if (v.is_st) st_q.push_back(v.exp); else ky_q.push_back(v.exp[31:0]);
    nis = v.is_st ? 4 : 1;
    lat = 0;
    got = 0;
    while (lat < 20 && !got) begin
      @(negedge clk); lat++;
      ky_req_valid = 0; st_req_valid = 0;
      if (lat <= nis) begin
        sh = v.is_st ? (v.data << (32 * (lat - 1))) : {v.data[31:0], 96'h0};
        check("sub_valid", sub_valid, 1);
        check("sub_word", sub_word, sh[127:96]);
        check("sub_dir", sub_dir, v.is_st ? v.dir : 1'b0);
      end else begin
        check("sub_idle", sub_valid, 0);
      end
      got = v.is_st ? st_rsp_valid : ky_rsp_valid;
    end
    check("latency", lat, v.is_st ? 5 : 2);
    if (got) begin
      if (v.is_st) check("st_rsp_data", st_rsp_data, st_q.pop_front());
      else         check("ky_rsp_word", ky_rsp_word, ky_q.pop_front());
    end
  endtask

  initial begin
    logic [7:0] y;
    logic [127:0] hold, d;
    logic exp_st, prev_st, need_new;
    int grants, issues, n, lat;

    for (int x = 0; x < 256; x++) begin
      y = 8'h00;
      for (int z = 1; z < 256; z++) if (x != 0 && gmul(8'(x), 8'(z)) == 8'h01) y = 8'(z);
      sb[x] = y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
      isb[sb[x]] = 8'(x);
    end

    vecs[0] = '{0, 0, 128'h0cf4f3c09, 128'h08a84eb01};
    vecs[1] = '{1, 0, 128'h0, {4{32'h63636363}}};
    vecs[2] = '{1, 1, {4{32'h63636363}}, 128'h0};
    vecs[3] = '{1, 0, 128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h637c777b_f26b6fc5_3001672b_fed7ab76};
    vecs[4] = '{1, 1, 128'h637c777b_f26b6fc5_3001672b_fed7ab76, 128'h00010203_04050607_08090a0b_0c0d0e0f};
    vecs[5] = '{0, 0, 128'h0, 128'h063636363};
    vecs[6] = '{0, 0, 128'h063636363, 128'h0fbfbfbfb};

    // reset: no acceptance and all outputs low even with requests pending
    ky_req_valid = 1; st_req_valid = 1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ky_ready", ky_req_ready, 0);
    check("rst_st_ready", st_req_ready, 0);
    check("rst_outs", {sub_valid, sub_dir, sub_word, ky_rsp_valid, st_rsp_valid}, 0);
    check("rst_data", {ky_rsp_word, st_rsp_data}, 0);
    ky_req_valid = 0; st_req_valid = 0;
    reset_n = 1;
    ky_rsp_ready = 1; st_rsp_ready = 1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // both requesters valid continuously: must alternate key/state
    @(negedge clk);
    ky_req_valid = 1; st_req_valid = 1;
    ky_req_word = $urandom; st_req_data = {$urandom, $urandom, $urandom, $urandom}; st_req_dir = 0;
    exp_st = 0; prev_st = 0; need_new = 0; grants = 0; issues = 0;
    // last grant was key (vecs[6]) so state wins first here
    exp_st = 1;
    for (int c = 0; c < 200 && grants < 8; c++) begin
      if (c > 0) @(negedge clk);
      if (need_new) begin
        if (prev_st) begin
          st_req_data = {$urandom, $urandom, $urandom, $urandom}; st_req_dir = ~st_req_dir;
        end else ky_req_word = $urandom;
        need_new = 0;
      end
      #1;
      if (sub_valid) issues++;
      if (ky_rsp_valid) begin
        if (ky_q.size() == 0) check("rr_ky_spurious", 1, 0);
        else check("rr_ky_word", ky_rsp_word, ky_q.pop_front());
      end
      if (st_rsp_valid) begin
        if (st_q.size() == 0) check("rr_st_spurious", 1, 0);
        else check("rr_st_data", st_rsp_data, st_q.pop_front());
      end
      if (ky_req_ready || st_req_ready) begin
        check("rr_one_ready", ky_req_ready & st_req_ready, 0);
        check("rr_grant", st_req_ready, exp_st);
        if (grants > 0) check("rr_issues", issues, prev_st ? 4 : 1);
        if (st_req_ready) st_q.push_back(substate(st_req_data, st_req_dir));
        else ky_q.push_back(subword(ky_req_word, 1'b0));
        issues = 0;
        prev_st = st_req_ready;
        exp_st = !st_req_ready;
        grants++;
        need_new = 1;
      end
    end
    check("rr_grants", grants, 8);
    @(negedge clk);
    ky_req_valid = 0; st_req_valid = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (ky_rsp_valid && ky_q.size() > 0) check("rr_ky_last", ky_rsp_word, ky_q.pop_front());
      if (st_rsp_valid && st_q.size() > 0) check("rr_st_last", st_rsp_data, st_q.pop_front());
      @(negedge clk);
    end
    check("rr_drained", ky_q.size() + st_q.size(), 0);

    // response stall: result held, no accept, no issue
    st_rsp_ready = 0;
    d = 128'h00112233_44556677_8899aabb_ccddeeff;
    st_req_valid = 1; st_req_dir = 1; st_req_data = d;
    n = 0; #1;
    while (!st_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    check("stall_accept", n < 20, 1);
    @(negedge clk);
    st_req_valid = 0; ky_req_valid = 1; ky_req_word = 32'h01020304;
    n = 0; #1;
    while (!st_rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
    check("stall_rsp_seen", st_rsp_valid, 1);
    hold = st_rsp_data;
    check("stall_data", hold, substate(d, 1'b1));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      check("stall_valid", st_rsp_valid, 1);
      check("stall_stable", st_rsp_data, hold);
      check("stall_no_accept", ky_req_ready, 0);
      check("stall_no_issue", sub_valid, 0);
    end
    st_rsp_ready = 1;
    @(negedge clk); #1;
    check("stall_release_valid", st_rsp_valid, 0);
    check("stall_release_idle", ky_req_ready, 1);
    ky_req_valid = 0;

    // reset asserted during ST_RUN at k=2
    @(negedge clk);
    d = 128'hdeadbeef_01234567_89abcdef_fedcba98;
    st_req_valid = 1; st_req_dir = 0; st_req_data = d;
    n = 0; #1;
    while (!st_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    check("rst_run_accept", n < 20, 1);
    repeat (3) @(negedge clk);
    st_req_valid = 0; ky_req_valid = 1; ky_req_word = 32'h11111111;
    #1;
    check("rst_run_k2", sub_word, 32'h89abcdef);
    reset_n = 0;
    #1;
    check("rst_run_ready", {ky_req_ready, st_req_ready}, 0);
    check("rst_run_outs", {sub_valid, sub_dir, sub_word, ky_rsp_valid, st_rsp_valid}, 0);
    check("rst_run_data", {ky_rsp_word, st_rsp_data}, 0);
    @(negedge clk);
    ky_req_valid = 0;
    reset_n = 1;
    run_vec(vecs[0]);

    // SUB_LAT=1 instance: capture one cycle after issue
    @(negedge clk);
    d = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    st_req_valid1 = 1; st_req_dir1 = 0; st_req_data1 = d;
    n = 0; #1;
    while (!st_req_ready1 && n < 20) begin @(negedge clk); #1; n++; end
    check("l1_st_accept", n < 20, 1);
    lat = 0;
    while (lat < 20 && !st_rsp_valid1) begin
      @(negedge clk); lat++;
      st_req_valid1 = 0;
      check("l1_st_issue", sub_valid1, lat <= 4);
    end
    check("l1_st_latency", lat, 6);
    check("l1_st_data", st_rsp_data1, 128'h637c777b_f26b6fc5_3001672b_fed7ab76);

    @(negedge clk);
    ky_req_valid1 = 1; ky_req_word1 = 32'hcf4f3c09;
    n = 0; #1;
    while (!ky_req_ready1 && n < 20) begin @(negedge clk); #1; n++; end
    check("l1_ky_accept", n < 20, 1);
    lat = 0;
    while (lat < 20 && !ky_rsp_valid1) begin
      @(negedge clk); lat++;
      ky_req_valid1 = 0;
    end
    check("l1_ky_latency", lat, 3);
    check("l1_ky_word", ky_rsp_word1, 32'h8a84eb01);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sbox_share_sched.md
Name: sbox_share_sched

Overview:
Time-multiplexes one external 32-bit word substitution unit between two requesters: key expansion (single-word SubWord, always forward) and the round datapath (128-bit SubBytes or InvSubBytes). Each state request is issued as four words, MSW first, and reassembled into a 128-bit result. Arbitration is round-robin at transaction granularity, with one transaction in flight at a time. Sits between the key-expansion/round controllers and the shared substitution unit.

Parameters:
SUB_LAT, 0, substitution unit latency in cycles: 0 = combinational result in the issue cycle, 1 = result one cycle after issue; other values are illegal.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
ky_req_valid  in  1  key SubWord request valid
ky_req_ready  out  1  key request accepted when valid&ready
ky_req_word  in  32  word to substitute
ky_rsp_valid  out  1  key result valid
ky_rsp_ready  in  1  key result consumed when valid&ready
ky_rsp_word  out  32  substituted word
st_req_valid  in  1  state request valid
st_req_ready  out  1  state request accepted
st_req_dir  in  1  0 = forward S-box, 1 = inverse
st_req_data  in  128  state matrix
st_rsp_valid  out  1  state result valid
st_rsp_ready  in  1  state result consumed
st_rsp_data  out  128  substituted state
sub_valid  out  1  issue strobe to substitution unit
sub_dir  out  1  direction for the issued word
sub_word  out  32  issued word
sub_result  in  32  substituted word from unit

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE, word counter=0, last_grant=STATE. All outputs 0: ready, rsp_valid, sub_valid, sub_dir, sub_word, rsp data. Any in-flight transaction is discarded. No request is accepted while reset_n=0.
- States:
  - IDLE
  - KY_RUN (issue)
  - ST_RUN (issue words 0..3)
  - DRAIN (SUB_LAT=1 only: capture last word)
  - KY_RSP
  - ST_RSP
- Request ready signals are combinational and only asserted in IDLE; at most one is high per cycle.
- Arbitration in IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - On accept: latch the request word/data and dir (key dir=0), update last_grant, clear counter.
- KY_RUN: sub_valid=1, sub_word=latched word, sub_dir=0, for one cycle.
- ST_RUN: four consecutive cycles, counter k=0..3. sub_word=data[127-32k -: 32], sub_dir=latched dir, sub_valid=1.
- Capture:
  - SUB_LAT=0: sub_result is captured in the issue cycle.
  - SUB_LAT=1: sub_result is captured the cycle after issue, into the slot of the word issued in the previous cycle (DRAIN captures the final word).
- Latency, accept cycle=0:
  - SUB_LAT=0: ky_rsp_valid at cycle 2, st_rsp_valid at cycle 5.
  - SUB_LAT=1: cycles 3 and 6 respectively.
- Response handling:
  - rsp_valid holds and rsp data stays stable until rsp_ready.
  - On handshake: go to IDLE next cycle and deassert rsp_valid.
  - The next request can be accepted in the cycle after the handshake.
- sub_valid=0 outside issue cycles. sub_word/sub_dir hold their last value when sub_valid=0.
- Requester valid dropping before accept is legal; no state change results.
- rsp_ready asserted while rsp_valid=0 is ignored.

Optional Feature:
SBOX_SCHED_PERF_EN:
- Defined: adds ports perf_clr (in, 1) and perf_ky_cnt, perf_st_cnt (out, 16 each). These are saturating counts of completed key/state response handshakes.
  - Counters reset to 0 and saturate at 16'hFFFF.
  - perf_clr clears both counters synchronously and has priority over increment.
- Undefined: these ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, SUB_LAT=0, key request cf4f3c09 with model S-box -> ky_req_ready=1 at cycle 0, sub_word=cf4f3c09 at cycle 1, ky_rsp_word=8a84eb01 with valid at cycle 2.
- State request with data=0, dir=0 -> sub_word=00000000 for 4 cycles, st_rsp_data=63636363_63636363_63636363_63636363 at cycle 5. Repeat with dir=1 and data all 63 -> result 0.
- Both requesters valid continuously after reset -> grant order key, state, key, state. sub_valid pattern is 1 issue, then 4 issues, per transaction; no request is starved.
- Hold st_rsp_ready=0 for 10 cycles -> st_rsp_valid and st_rsp_data are stable, no new accept, sub_valid=0. Raise ready -> IDLE next cycle.
- SUB_LAT=1, state data 00010203_04050607_08090a0b_0c0d0e0f, dir=0 -> result 637c777b_f26b6fc5_3001672b_fe d7ab76 with valid at cycle 6, each word captured one cycle after issue.
- Assert reset_n=0 during ST_RUN k=2 -> all outputs 0 immediately. After release, IDLE; a fresh key request completes with correct data.
